// File: rtl/udp_echo_client_gen.sv
// udp_echo_client_gen
//   Transmit-side traffic source for the UDP echo path. One configuration
//   handshake starts a run of N UDP application messages. Each message is a
//   header flit, a metadata flit and zero or more payload flits, sent on the
//   NoC0 output.
//   Payload byte k of packet number seq is (seq[7:0] + k) mod 256.
//   Packets are separated by a programmable number of idle cycles.
//   Cumulative packet and byte counters survive across runs. Only reset
//   clears them.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_val / cfg_rdy          run configuration handshake (rdy only in IDLE)
//   cfg_*                      run fields: destination tile, IPs, ports,
//                              payload length, packet count, gap
//   gen_out_noc0_val/_data     flit output toward the UDP TX tile
//   noc0_gen_out_rdy           downstream ready
//   busy, done                 run in progress / one-cycle end-of-run pulse
//   stat_pkts_sent/_bytes_sent cumulative completed packets / payload bytes
module udp_echo_client_gen #(
    parameter int unsigned NOC_DATA_W  = 512,
    parameter logic [7:0]  SRC_X       = 8'h00,
    parameter logic [7:0]  SRC_Y       = 8'h00,
    parameter logic [7:0]  MSG_TYPE    = 8'h01,
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_val,
    output logic                  cfg_rdy,
    input  logic [7:0]            cfg_dst_x,
    input  logic [7:0]            cfg_dst_y,
    input  logic [31:0]           cfg_src_ip,
    input  logic [31:0]           cfg_dst_ip,
    input  logic [15:0]           cfg_src_port,
    input  logic [15:0]           cfg_dst_port,
    input  logic [15:0]           cfg_len,
    input  logic [31:0]           cfg_num_pkts,
    input  logic [15:0]           cfg_gap,
    output logic                  gen_out_noc0_val,
    output logic [NOC_DATA_W-1:0] gen_out_noc0_data,
    input  logic                  noc0_gen_out_rdy,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stat_pkts_sent,
    output logic [63:0]           stat_bytes_sent
);

    localparam int unsigned FLIT_BYTES = NOC_DATA_W / 8;
    localparam logic [15:0] MAX_LEN    = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_META = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    typedef struct packed {
        logic [7:0]  dst_x;
        logic [7:0]  dst_y;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] len;        // already clamped to MAX_LEN
        logic [15:0] data_flits; // ceil(len / FLIT_BYTES), cached at accept
        logic [31:0] num_pkts;
        logic [15:0] gap;
    } cfg_t;

    function automatic logic [15:0] calc_flits(input logic [15:0] len);
        logic [31:0] n;
        n = (32'(len) + 32'(FLIT_BYTES) - 32'd1) / 32'(FLIT_BYTES);
        return n[15:0];
    endfunction

    function automatic logic [NOC_DATA_W-1:0] build_hdr(input logic [7:0] dx, input logic [7:0] dy,
                                                        input logic [21:0] msg_len);
        logic [NOC_DATA_W-1:0] f;
        f = '0;
        f[NOC_DATA_W-1 -: 62] = {dx, dy, SRC_X, SRC_Y, msg_len, MSG_TYPE};
        return f;
    endfunction

    function automatic logic [NOC_DATA_W-1:0] build_meta(input cfg_t c);
        logic [NOC_DATA_W-1:0] f;
        f = '0;
        f[NOC_DATA_W-1 -: 112] = {c.src_ip, c.dst_ip, c.src_port, c.dst_port, c.len};
        return f;
    endfunction

    // Byte j of data flit idx is payload byte k = idx*FLIT_BYTES + j, MSB byte first
    function automatic logic [NOC_DATA_W-1:0] build_data(input logic [7:0] seq8, input logic [15:0] idx,
                                                         input logic [15:0] len);
        logic [NOC_DATA_W-1:0] f;
        logic [31:0]           k;
        f = '0;
        for (int j = 0; j < int'(FLIT_BYTES); j++) begin
            k = 32'(idx) * 32'(FLIT_BYTES) + 32'(j);
            if (k < 32'(len)) begin
                f[NOC_DATA_W-1-8*j -: 8] = seq8 + k[7:0];
            end else begin
                f[NOC_DATA_W-1-8*j -: 8] = 8'h00;
            end
        end
        return f;
    endfunction

    state_t                state_r, state_nxt_s, after_pkt_s;
    cfg_t                  cfg_r, cfg_nxt_s;
    logic [31:0]           seq_r, seq_nxt_s;
    logic [15:0]           idx_r, idx_nxt_s;
    logic [15:0]           gap_cnt_r, gap_cnt_nxt_s;
    logic [15:0]           len_clamp_s;
    logic                  accept_s, hs_s, complete_s;
    logic                  val_r, busy_r, done_r, cfg_rdy_r;
    logic [NOC_DATA_W-1:0] data_r, flit_nxt_s;
    logic [31:0]           stat_pkts_r;
    logic [63:0]           stat_bytes_r;

    assign len_clamp_s = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
    assign accept_s    = (state_r == ST_IDLE) && cfg_rdy_r && cfg_val;
    assign hs_s        = val_r && noc0_gen_out_rdy;
    // Last flit of a message: metadata when there is no payload, else final data flit
    assign complete_s  = hs_s && (((state_r == ST_META) && (cfg_r.data_flits == 16'd0)) ||
                                  ((state_r == ST_DATA) && (idx_r == cfg_r.data_flits - 16'd1)));
    assign after_pkt_s = (seq_r + 32'd1 == cfg_r.num_pkts) ? ST_DONE :
                         ((cfg_r.gap == 16'd0) ? ST_HDR : ST_GAP);

    // Next-state and next-datapath logic
    always_comb begin
        state_nxt_s   = state_r;
        cfg_nxt_s     = cfg_r;
        seq_nxt_s     = seq_r;
        idx_nxt_s     = idx_r;
        gap_cnt_nxt_s = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cfg_nxt_s = '{dst_x: cfg_dst_x, dst_y: cfg_dst_y, src_ip: cfg_src_ip,
                                  dst_ip: cfg_dst_ip, src_port: cfg_src_port, dst_port: cfg_dst_port,
                                  len: len_clamp_s, data_flits: calc_flits(len_clamp_s),
                                  num_pkts: cfg_num_pkts, gap: cfg_gap};
                    seq_nxt_s   = 32'd0;
                    state_nxt_s = (cfg_num_pkts == 32'd0) ? ST_DONE : ST_HDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (hs_s) begin
                    state_nxt_s = ST_META;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_META: begin
                if (complete_s) begin
                    state_nxt_s   = after_pkt_s;
                    seq_nxt_s     = seq_r + 32'd1;
                    gap_cnt_nxt_s = cfg_r.gap;
                end else if (hs_s) begin
                    state_nxt_s = ST_DATA;
                    idx_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = ST_META;
                end
            end
            ST_DATA: begin
                if (complete_s) begin
                    state_nxt_s   = after_pkt_s;
                    seq_nxt_s     = seq_r + 32'd1;
                    gap_cnt_nxt_s = cfg_r.gap;
                end else if (hs_s) begin
                    idx_nxt_s = idx_r + 16'd1;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_GAP: begin
                // Loaded with cfg_gap on entry, so this state lasts exactly cfg_gap cycles
                if (gap_cnt_r <= 16'd1) begin
                    state_nxt_s = ST_HDR;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r - 16'd1;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Flit image for the next cycle, formed from the values the registers are about to take
    always_comb begin
        flit_nxt_s = '0;
        case (state_nxt_s)
            ST_HDR:  flit_nxt_s = build_hdr(cfg_nxt_s.dst_x, cfg_nxt_s.dst_y,
                                            22'(cfg_nxt_s.data_flits) + 22'd2);
            ST_META: flit_nxt_s = build_meta(cfg_nxt_s);
            ST_DATA: flit_nxt_s = build_data(seq_nxt_s[7:0], idx_nxt_s, cfg_nxt_s.len);
            default: flit_nxt_s = '0;
        endcase
    end

    // State, configuration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cfg_r     <= '0;
            seq_r     <= 32'd0;
            idx_r     <= 16'd0;
            gap_cnt_r <= 16'd0;
            val_r     <= 1'b0;
            data_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cfg_rdy_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cfg_r     <= cfg_nxt_s;
            seq_r     <= seq_nxt_s;
            idx_r     <= idx_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
            val_r     <= (state_nxt_s == ST_HDR) || (state_nxt_s == ST_META) || (state_nxt_s == ST_DATA);
            data_r    <= flit_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
            cfg_rdy_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Cumulative statistics, advanced on the handshake of each message's last flit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts_r  <= 32'd0;
            stat_bytes_r <= 64'd0;
        end else if (complete_s) begin
            stat_pkts_r  <= stat_pkts_r + 32'd1;
            stat_bytes_r <= stat_bytes_r + {48'd0, cfg_r.len};
        end else begin
            stat_pkts_r  <= stat_pkts_r;
            stat_bytes_r <= stat_bytes_r;
        end
    end

    assign cfg_rdy           = cfg_rdy_r;
    assign gen_out_noc0_val  = val_r;
    assign gen_out_noc0_data = data_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign stat_pkts_sent    = stat_pkts_r;
    assign stat_bytes_sent   = stat_bytes_r;

endmodule

// File: tb/tb_udp_echo_client_gen.sv
// Self-checking bench for udp_echo_client_gen. Expected flit streams come
// from a byte-level message model built from the message format.
// Randomised configuration fields and ready stalls drive the DUT.
module tb_udp_echo_client_gen;

    localparam int W  = 512;
    localparam int FB = W / 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_val;
    logic         cfg_rdy;
    logic [7:0]   cfg_dst_x, cfg_dst_y;
    logic [31:0]  cfg_src_ip, cfg_dst_ip;
    logic [15:0]  cfg_src_port, cfg_dst_port;
    logic [15:0]  cfg_len;
    logic [31:0]  cfg_num_pkts;
    logic [15:0]  cfg_gap;
    logic         out_val;
    logic [W-1:0] out_data;
    logic         out_rdy;
    logic         busy, done;
    logic [31:0]  stat_pkts_sent;
    logic [63:0]  stat_bytes_sent;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  exp_pkts  = 32'd0;
    logic [63:0]  exp_bytes = 64'd0;

    always #5 clk = ~clk;

    udp_echo_client_gen #(
        .NOC_DATA_W(W), .SRC_X(8'h00), .SRC_Y(8'h00), .MSG_TYPE(8'h01), .MAX_PAYLOAD(1472)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
        .cfg_dst_x(cfg_dst_x), .cfg_dst_y(cfg_dst_y), .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
        .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port), .cfg_len(cfg_len),
        .cfg_num_pkts(cfg_num_pkts), .cfg_gap(cfg_gap),
        .gen_out_noc0_val(out_val), .gen_out_noc0_data(out_data), .noc0_gen_out_rdy(out_rdy),
        .busy(busy), .done(done), .stat_pkts_sent(stat_pkts_sent), .stat_bytes_sent(stat_bytes_sent)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, " stat_pkts"}, W'(stat_pkts_sent), W'(exp_pkts));
        chk({tag, " stat_bytes"}, W'(stat_bytes_sent), W'(exp_bytes));
    endtask

    task automatic scramble_cfg();
        cfg_dst_x    = 8'($urandom);
        cfg_dst_y    = 8'($urandom);
        cfg_src_ip   = $urandom;
        cfg_dst_ip   = $urandom;
        cfg_src_port = 16'($urandom);
        cfg_dst_port = 16'($urandom);
        cfg_len      = 16'($urandom);
        cfg_num_pkts = $urandom;
        cfg_gap      = 16'($urandom);
    endtask

    // Message model: payload of packet p is the byte sequence (p + k) mod 256,
    // cut into FB-byte flits with the tail zero-filled.
    task automatic build_model(input logic [7:0] dx, input logic [7:0] dy, input logic [31:0] sip,
                               input logic [31:0] dip, input logic [15:0] sp, input logic [15:0] dp,
                               input logic [15:0] len, input int npk);
        int           nd;
        logic [W-1:0] f;
        byte unsigned payload[$];
        nd = (int'(len) + FB - 1) / FB;
        for (int p = 0; p < npk; p++) begin
            f = '0;
            f[W-1 -: 62] = {dx, dy, 8'h00, 8'h00, 22'(nd + 2), 8'h01};
            exp_q.push_back(f);
            f = '0;
            f[W-1 -: 112] = {sip, dip, sp, dp, len};
            exp_q.push_back(f);
            payload.delete();
            for (int k = 0; k < int'(len); k++) payload.push_back(8'((p + k) % 256));
            while (payload.size() % FB != 0) payload.push_back(8'h00);
            for (int d = 0; d < nd; d++) begin
                f = '0;
                for (int b = 0; b < FB; b++) f[W-1-8*b -: 8] = payload[d*FB + b];
                exp_q.push_back(f);
            end
        end
    endtask

    task automatic do_run(input string name, input logic [15:0] len_in, input int npk,
                          input logic [15:0] gap, input bit stall, input bit hold);
        logic [7:0]   dx, dy;
        logic [31:0]  sip, dip;
        logic [15:0]  sp, dp, len;
        int           nd, fpp, fidx, last_c, done_c, waited, exp_done;
        logic [W-1:0] prev_data;
        bit           prev_stall;
        dx  = 8'($urandom);
        dy  = 8'($urandom);
        sip = $urandom;
        dip = $urandom;
        sp  = 16'($urandom);
        dp  = 16'($urandom);
        len = (len_in > 16'd1472) ? 16'd1472 : len_in;
        nd  = (int'(len) + FB - 1) / FB;
        fpp = 2 + nd;
        exp_q.delete();
        build_model(dx, dy, sip, dip, sp, dp, len, npk);

        waited = 0;
        @(negedge clk);
        while (cfg_rdy !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({name, " cfg_rdy idle"}, W'(cfg_rdy), W'(1'b1));
        cfg_val      = 1'b1;
        cfg_dst_x    = dx;
        cfg_dst_y    = dy;
        cfg_src_ip   = sip;
        cfg_dst_ip   = dip;
        cfg_src_port = sp;
        cfg_dst_port = dp;
        cfg_len      = len_in;
        cfg_num_pkts = 32'(npk);
        cfg_gap      = gap;
        @(posedge clk);
        #1;
        // Configuration must be ignored while busy: keep val (optionally) and garble fields
        cfg_val = hold;
        scramble_cfg();

        fidx = 0; last_c = 0; done_c = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 1; c <= 3000 && done_c == 0; c++) begin
            out_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (c == 1) chk({name, " busy after accept"}, W'(busy), W'(1'b1));
            if (prev_stall) begin
                chk({name, " val held in stall"}, W'(out_val), W'(1'b1));
                chk({name, " data held in stall"}, out_data, prev_data);
            end
            if (done === 1'b1) begin
                done_c = c;
                chk({name, " val at done"}, W'(out_val), W'(1'b0));
            end
            if (out_val === 1'b1 && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk({name, " extra flit"}, W'(1'b1), W'(1'b0));
                end else begin
                    chk($sformatf("%s flit%0d", name, fidx), out_data, exp_q.pop_front());
                end
                if (!stall && fidx > 0 && fidx % fpp == 0)
                    chk({name, " gap cycles"}, W'(c - last_c), W'(int'(gap) + 1));
                if (fidx % fpp == fpp - 1) begin
                    exp_pkts  = exp_pkts + 32'd1;
                    exp_bytes = exp_bytes + 64'(len);
                end
                last_c = c;
                fidx++;
            end
            prev_stall = (out_val === 1'b1) && !out_rdy;
            prev_data  = out_data;
            if (done_c != 0) chk_stats({name, " at done"});
            @(posedge clk);
            #1;
        end
        cfg_val = 1'b0;
        chk({name, " done seen"}, W'(done_c != 0), W'(1'b1));
        chk({name, " flits left"}, W'(exp_q.size()), W'(0));
        if (!stall) begin
            exp_done = (npk == 0) ? 1 : npk * fpp + (npk - 1) * int'(gap) + 1;
            chk({name, " done latency"}, W'(done_c), W'(exp_done));
        end
        chk({name, " done one cycle"}, W'(done), W'(1'b0));
        chk({name, " busy low after done"}, W'(busy), W'(1'b0));
        chk({name, " cfg_rdy after done"}, W'(cfg_rdy), W'(1'b1));
        chk_stats({name, " after run"});
    endtask

    initial begin
        rst_n   = 1'b0;
        cfg_val = 1'b0;
        out_rdy = 1'b1;
        scramble_cfg();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset val", W'(out_val), W'(1'b0));
        chk("reset data", out_data, '0);
        chk("reset cfg_rdy", W'(cfg_rdy), W'(1'b0));
        chk("reset busy", W'(busy), W'(1'b0));
        chk("reset done", W'(done), W'(1'b0));
        chk_stats("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("cfg_rdy after release", W'(cfg_rdy), W'(1'b1));

        do_run("len64",    16'd64,   1, 16'd0, 1'b0, 1'b1);
        do_run("len0",     16'd0,    2, 16'd0, 1'b0, 1'b0);
        do_run("len100g5", 16'd100,  3, 16'd5, 1'b0, 1'b1);
        do_run("stall200", 16'd200,  4, 16'd2, 1'b1, 1'b0);
        do_run("b2b200",   16'd200,  3, 16'd0, 1'b0, 1'b0);
        do_run("clamp",    16'd2000, 2, 16'd1, 1'b0, 1'b0);
        do_run("npk0",     16'd64,   0, 16'd3, 1'b0, 1'b0);

        // Reset in the middle of a payload: message abandoned, stats cleared
        @(negedge clk);
        cfg_val      = 1'b1;
        cfg_len      = 16'd200;
        cfg_num_pkts = 32'd3;
        cfg_gap      = 16'd0;
        out_rdy      = 1'b1;
        @(posedge clk);
        #1;
        cfg_val = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid-data val before reset", W'(out_val), W'(1'b1));
        rst_n = 1'b0;
        #1;
        exp_pkts  = 32'd0;
        exp_bytes = 64'd0;
        chk("mid-data reset val", W'(out_val), W'(1'b0));
        chk("mid-data reset data", out_data, '0);
        chk("mid-data reset cfg_rdy", W'(cfg_rdy), W'(1'b0));
        chk("mid-data reset busy", W'(busy), W'(1'b0));
        chk_stats("mid-data reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("cfg_rdy after mid-data release", W'(cfg_rdy), W'(1'b1));
        chk("val after mid-data release", W'(out_val), W'(1'b0));
        chk_stats("after mid-data release");

        do_run("post-reset", 16'd65, 2, 16'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
